cnn_conv1_mac_sched: RTL and testbench
======================================

Name: cnn_conv1_mac_sched

Overview:
Time-shares one 14-bit-signed x 6-bit-unsigned multiplier among NREQ conv1 kernel lanes. Each lane streams (activation, weight, last) tuples and receives its accumulated dot product. The block sits between the conv1 lane sequencers and the shared multiplier. It provides per-lane accumulation, round-robin arbitration and per-lane result handshakes.

Parameters:
NREQ, 4, number of requesting lanes (2..8)
A_W, 14, activation width, signed
B_W, 6, weight width, unsigned
P_W, 20, product width, signed (A_W+B_W)
ACC_W, 24, accumulator/result width, signed

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  lane i has an operand pair
req_ready  out  NREQ  lane i operand accepted this cycle (one-hot or zero)
req_a  in  NREQ*A_W  lane i activation, slice [i*A_W +: A_W], signed
req_b  in  NREQ*B_W  lane i weight, slice [i*B_W +: B_W], unsigned
req_last  in  NREQ  final pair of lane i's dot product
res_valid  out  NREQ  lane i result available
res_ready  in  NREQ  lane i result consumed
res_data  out  NREQ*ACC_W  lane i result, slice [i*ACC_W +: ACC_W], signed
busy  out  1  stage-1 occupied or any lane has an open (unterminated) sequence

Behaviour:
- Reset: req_ready, res_valid, res_data, busy = 0. All accumulators, open flags and stage-1 contents are cleared. The RR pointer is set to NREQ-1, so lane 0 has first priority.
- Eligibility: lane i is eligible when req_valid[i]=1, res_valid[i]=0, and stage 1 holds no last-op for lane i.
- Arbitration: combinational round-robin. Search starts at ptr+1 and wraps modulo NREQ. The first eligible lane gets req_ready[i]=1. At most one grant per cycle.
- Grant side effects: on a grant, ptr <= i. If no lane is eligible, ptr holds.
- Handshake: a transfer occurs at an edge where req_valid[i] & req_ready[i]. req_ready does not depend on res_ready in the same cycle.
- Stage 1 (edge T, transfer): register a, b, lane index, last; s1_valid <= 1. If no transfer, s1_valid <= 0.
- Stage 2 (edge T+1): compute p = signed(a) * signed({1'b0,b}), P_W bits exact.
  - Sign-extend p to ACC_W and form sum = acc[idx] + p.
  - Sum is modulo 2^ACC_W; two's-complement wrap, no saturation.
  - last=0: acc[idx] <= sum; open[idx] <= 1.
  - last=1: res_data[idx] <= sum; res_valid[idx] <= 1; acc[idx] <= 0; open[idx] <= 0.
- Latency: transfer at edge T gives res_valid high after edge T+1. Throughput is one operand pair per cycle in aggregate.
- Result handshake: res_valid[i] clears at an edge where res_valid[i] & res_ready[i]. res_data[i] holds its value until the next last-op for that lane overwrites it.
- Simultaneous pop and grant: a lane popping its result in cycle C is not eligible in cycle C (res_valid still 1). It becomes eligible in C+1.
- Single-pair sequence: a last=1 pair with no prior pairs gives result = p.
- Reset mid-operation: the stage-1 op and all partial sums are discarded. Lanes must restart their sequences.
- busy = s1_valid | OR(open).
- No X propagation: unselected lanes' operands never reach the multiplier (the mux is driven by the registered index).

Decomposition:
- Shared package cnn_conv1_pkg holds:
  - constants A_W, B_W, P_W, ACC_W, NREQ_DEFAULT;
  - a function sext_p2acc (P_W to ACC_W);
  - a typedef for the stage-1 record {a, b, idx, last}.
- One sub-module, cnn_rr_arbiter: parameter N; inputs req[N], ptr; outputs grant[N] one-hot and gnt_idx. It is purely combinational; ptr is registered in the parent.
- The multiply itself stays inline in stage 2 (a single DSP inference).

Test Plan:
- Lane 0: a=-8192, b=63, last=1 -> two edges later res_valid[0]=1, res_data[0]=0xF82000 (-516096). Lane stays ineligible until res_ready[0].
- Lane 1: pairs (100,2), (-50,3), (7,63,last) on consecutive cycles -> res_data[1]=491. busy=1 throughout, busy=0 one cycle after completion.
- All 4 lanes valid continuously with last=0 -> grants 0,1,2,3,0,1... one per cycle. No lane is granted twice before the others.
- Lane 2 result held (res_ready[2]=0) -> req_ready[2]=0 while lanes 0,1,3 rotate. Pulse res_ready[2] -> lane 2 is granted the following cycle.
- Lane 3: 17 pairs of (8191,63), last on the 17th -> the sum wraps: res_data[3]=-8004655 (0x85DBD1).
- Lane 0 sends 2 non-last pairs, then ap_rst_n is pulsed low asynchronously -> all outputs 0 immediately. A new (5,4,last) sequence then yields 20, not an accumulated value.

Source files
------------

// File: rtl/cnn_conv1_pkg.sv
// cnn_conv1_pkg: shared widths, stage-1 record and product sign-extension helper
// for the conv1 MAC scheduler.
package cnn_conv1_pkg;
  localparam int A_W = 14;
  localparam int B_W = 6;
  localparam int P_W = A_W + B_W;
  localparam int ACC_W = 24;
  localparam int NREQ_DEFAULT = 4;
  localparam int IDX_W = 3;
  typedef struct packed {
    logic signed [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [IDX_W-1:0] idx;
    logic last;
  } s1_rec_t;
  function automatic logic signed [ACC_W-1:0] sext_p2acc(input logic signed [P_W-1:0] p);
    return {{(ACC_W-P_W){p[P_W-1]}}, p};
  endfunction
endpackage

// File: rtl/cnn_rr_arbiter.sv
// cnn_rr_arbiter: combinational round-robin pick, searching from ptr+1 upward with wrap.
module cnn_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] c;
  logic found;
  always_comb begin
    grant = '0;
    gnt_idx = '0;
    found = 1'b0;
    c = '0;
    for (int k = 1; k <= N; k++) begin
      c = IW'((int'(ptr) + k) % N);
      if (!found && req[c]) begin
        grant[c] = 1'b1;
        gnt_idx = c;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cnn_conv1_mac_sched.sv
// cnn_conv1_mac_sched: time-shares one signed x unsigned multiplier among NREQ conv1 lanes,
// accumulating each lane's dot product and returning it through a per-lane result handshake.
module cnn_conv1_mac_sched
  import cnn_conv1_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*A_W-1:0]   req_a,
  input  logic [NREQ*B_W-1:0]   req_b,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       res_valid,
  input  logic [NREQ-1:0]       res_ready,
  output logic [NREQ*ACC_W-1:0] res_data,
  output logic                  busy
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] elig, grant, open_q, res_valid_q;
  logic [IW-1:0] gnt_idx, ptr_q, s1_idx;
  s1_rec_t s1_q, s1_d;
  logic s1_valid_q;
  logic signed [ACC_W-1:0] acc_q [NREQ];
  logic [NREQ*ACC_W-1:0] res_data_q;
  logic signed [P_W-1:0] prod;
  logic signed [ACC_W-1:0] sum;
  // A lane whose last op sits in stage 1 must wait until its result is registered.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = ap_rst_n & req_valid[i] & ~res_valid_q[i]
              & ~(s1_valid_q & s1_q.last & (s1_q.idx == IDX_W'(i)));
  end
  cnn_rr_arbiter #(.N(NREQ)) u_arb (
    .req     (elig),
    .ptr     (ptr_q),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );
  assign s1_d = '{a: req_a[gnt_idx*A_W +: A_W], b: req_b[gnt_idx*B_W +: B_W],
                  idx: IDX_W'(gnt_idx), last: req_last[gnt_idx]};
  assign s1_idx = IW'(s1_q.idx);
  assign prod = P_W'($signed(s1_q.a)) * P_W'($signed({1'b0, s1_q.b}));
  assign sum = acc_q[s1_idx] + sext_p2acc(prod);
  assign req_ready = grant;
  assign res_valid = res_valid_q;
  assign res_data = res_data_q;
  assign busy = s1_valid_q | (|open_q);
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q <= IW'(NREQ - 1);
      s1_valid_q <= 1'b0;
      s1_q <= '0;
      open_q <= '0;
      res_valid_q <= '0;
      res_data_q <= '0;
      for (int i = 0; i < NREQ; i++) acc_q[i] <= '0;
    end else begin
      s1_valid_q <= |grant;
      if (|grant) begin
        ptr_q <= gnt_idx;
        s1_q <= s1_d;
      end
      res_valid_q <= res_valid_q & ~res_ready;
      if (s1_valid_q) begin
        acc_q[s1_idx] <= s1_q.last ? '0 : sum;
        open_q[s1_idx] <= ~s1_q.last;
        if (s1_q.last) begin
          res_data_q[s1_idx*ACC_W +: ACC_W] <= sum;
          res_valid_q[s1_idx] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cnn_conv1_mac_sched.sv
// tb_cnn_conv1_mac_sched: scoreboard bench; per-lane running dot products predict each result,
// a monitor pops and compares on every result handshake.
module tb_cnn_conv1_mac_sched;
  localparam int N = 4, AW = 14, BW = 6, AC = 24;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_last = '0, res_valid, res_ready = '0;
  logic [N*AW-1:0] req_a = '0;
  logic [N*BW-1:0] req_b = '0;
  logic [N*AC-1:0] res_data;
  logic busy;

  typedef struct {int a; int b; bit last;} op_t;
  op_t op_q[N][$];
  logic [AC-1:0] exp_q[N][$];
  longint sum[N];
  int pend[N] = '{default: -100};
  bit hold[N];
  bit [N-1:0] xfer_s, rv_prev;
  int gnt_log[$];
  bit rr_win, pulse_req, pulse_done;
  int last_gnt = -1, pulse_at = -10, cyc = 0;
  int compared = 0, mismatched = 0;

  always #5 ap_clk = ~ap_clk;

  cnn_conv1_mac_sched #(.NREQ(N)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_last  (req_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  function automatic void chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic bit idle();
    bit r = !busy;
    for (int i = 0; i < N; i++)
      if (op_q[i].size() != 0 || (!hold[i] && (exp_q[i].size() != 0 || res_valid[i]))) r = 1'b0;
    return r;
  endfunction

  task automatic push(input int l, input int a, input int b, input bit last);
    op_q[l].push_back('{a: a, b: b, last: last});
  endtask

  task automatic step();
    @(negedge ap_clk);
    #1;
  endtask

  task automatic drain(input string name, input int bound);
    int k = 0;
    while (k < bound && !idle()) begin step(); k++; end
    chk({name, " drain"}, longint'(k < bound), 1);
  endtask

  task automatic wait_rv(input int l, input int bound);
    int k = 0;
    while (!res_valid[l] && k < bound) begin step(); k++; end
    chk($sformatf("lane%0d res_valid", l), longint'(res_valid[l]), 1);
  endtask

  // Driver: holds each lane's head op until it is accepted, randomises idle operands.
  initial begin
    forever begin
      for (int i = 0; i < N; i++) begin
        if (xfer_s[i] && op_q[i].size() > 0) void'(op_q[i].pop_front());
        if (op_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_a[i*AW +: AW] = AW'(op_q[i][0].a);
          req_b[i*BW +: BW] = BW'(op_q[i][0].b);
          req_last[i] = op_q[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
          req_a[i*AW +: AW] = AW'($urandom);
          req_b[i*BW +: BW] = BW'($urandom);
          req_last[i] = 1'($urandom);
        end
        res_ready[i] = hold[i] ? 1'b0 : 1'($urandom_range(0, 1));
      end
      if (pulse_req && !pulse_done && last_gnt == 0) begin
        res_ready[2] = 1'b1;
        pulse_done = 1'b1;
        pulse_at = cyc + 1;
      end
      @(posedge ap_clk);
      #1;
    end
  end

  // Monitor: reference model updates on transfers, scoreboard compares on result handshakes.
  initial begin
    forever begin
      @(negedge ap_clk);
      cyc++;
      chk("req_ready one-hot", longint'($countones(req_ready) <= 1), 1);
      if (cyc == pulse_at + 1) chk("lane2 granted after pop", longint'(req_ready[2]), 1);
      for (int i = 0; i < N; i++) begin
        if (!ap_rst_n) sum[i] = 0;
        xfer_s[i] = req_valid[i] & req_ready[i];
        if (res_valid[i] && !rv_prev[i]) chk($sformatf("lane%0d latency", i), cyc - pend[i], 2);
        if (res_valid[i]) chk($sformatf("lane%0d ready while result held", i), longint'(req_ready[i]), 0);
        if (res_valid[i] && res_ready[i]) begin
          if (exp_q[i].size() == 0) chk($sformatf("lane%0d unexpected result", i), 0, 1);
          else chk($sformatf("lane%0d result", i), longint'($signed(res_data[i*AC +: AC])),
                   longint'($signed(exp_q[i].pop_front())));
        end
        rv_prev[i] = res_valid[i];
        if (xfer_s[i]) begin
          sum[i] += longint'($signed(req_a[i*AW +: AW])) * longint'(req_b[i*BW +: BW]);
          if (req_last[i]) begin
            exp_q[i].push_back(AC'(sum[i]));
            sum[i] = 0;
            pend[i] = cyc;
          end
          last_gnt = i;
          if (rr_win) gnt_log.push_back(i);
        end
      end
    end
  end

  initial begin
    int k;
    for (int l = 0; l < N; l++) begin
      repeat (8) push(l, l + 1, 3, 1'b0);
      push(l, -l, 5, 1'b1);
    end
    repeat (3) @(posedge ap_clk);
    #2;
    chk("reset req_ready", longint'(req_ready), 0);
    chk("reset res_valid", longint'(res_valid), 0);
    chk("reset res_data", longint'(res_data), 0);
    chk("reset busy", longint'(busy), 0);
    rr_win = 1'b1;
    ap_rst_n = 1'b1;
    drain("rr", 200);
    rr_win = 1'b0;
    chk("rr grant count", gnt_log.size(), 36);
    foreach (gnt_log[j]) chk($sformatf("rr grant %0d", j), gnt_log[j], j % 4);

    hold[0] = 1'b1;
    push(0, -8192, 63, 1'b1);
    wait_rv(0, 20);
    chk("lane0 min x max", longint'(res_data[0 +: AC]), 64'hF82000);
    push(0, 1, 1, 1'b1);
    repeat (4) step();
    hold[0] = 1'b0;
    drain("lane0", 100);

    push(1, 100, 2, 1'b0);
    push(1, -50, 3, 1'b0);
    push(1, 7, 63, 1'b1);
    k = 0;
    while (!busy && k < 10) begin step(); k++; end
    chk("lane1 busy rise", longint'(busy), 1);
    k = 0;
    while (!res_valid[1] && k < 10) begin chk("lane1 busy mid", longint'(busy), 1); step(); k++; end
    chk("lane1 res_valid", longint'(res_valid[1]), 1);
    chk("lane1 busy after", longint'(busy), 0);
    chk("lane1 result", longint'($signed(res_data[AC +: AC])), 491);
    drain("lane1", 100);

    hold[2] = 1'b1;
    push(2, 3, 5, 1'b1);
    wait_rv(2, 20);
    foreach (op_q[l]) begin
      repeat (12) push(l, int'($urandom_range(0, 16383)) - 8192, $urandom_range(0, 63), 1'b0);
      push(l, 9, 9, 1'b1);
    end
    repeat (6) step();
    pulse_req = 1'b1;
    k = 0;
    while (!pulse_done && k < 20) begin step(); k++; end
    chk("lane2 pulse issued", longint'(pulse_done), 1);
    repeat (3) step();
    hold[2] = 1'b0;
    drain("lane2", 300);

    hold[3] = 1'b1;
    repeat (16) push(3, 8191, 63, 1'b0);
    push(3, 8191, 63, 1'b1);
    wait_rv(3, 80);
    chk("lane3 wrap", longint'(res_data[3*AC +: AC]), 64'h85DBD1);
    hold[3] = 1'b0;
    drain("lane3", 100);

    push(0, 11, 2, 1'b0);
    push(0, 13, 3, 1'b0);
    k = 0;
    while (op_q[0].size() != 0 && k < 20) begin step(); k++; end
    chk("lane0 partial accepted", op_q[0].size(), 0);
    @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b0;
    #1;
    chk("async reset req_ready", longint'(req_ready), 0);
    chk("async reset res_valid", longint'(res_valid), 0);
    chk("async reset res_data", longint'(res_data), 0);
    chk("async reset busy", longint'(busy), 0);
    push(1, 7, 7, 1'b1);
    @(posedge ap_clk);
    #2;
    chk("reset held req_ready", longint'(req_ready), 0);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    hold[0] = 1'b1;
    push(0, 5, 4, 1'b1);
    wait_rv(0, 20);
    chk("lane0 after reset", longint'(res_data[0 +: AC]), 20);
    hold[0] = 1'b0;
    drain("reset", 100);

    for (int n = 0; n < 240; n++)
      push($urandom_range(0, N - 1), int'($urandom_range(0, 16383)) - 8192,
           $urandom_range(0, 63), $urandom_range(0, 3) == 0);
    for (int l = 0; l < N; l++) push(l, int'($urandom_range(0, 16383)) - 8192, 63, 1'b1);
    drain("random", 4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
